parity_sched: RTL and testbench

PARITY_SCHED -- requirements
Module: parity_sched

---
 rtl/parity_pkg.sv | 6 +
 rtl/rr_arb2.sv | 19 +
 rtl/parity_sched.sv | 104 ++++++++++
 tb/tb_parity_sched.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared state encoding and requester ids for parity_sched.
package parity_pkg;
    typedef enum logic [1:0] {IDLE, CLASSIFY, OUTPUT} state_t;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
// Ports: i_valid - request valids (bit n = requester n)
//        i_last  - id served last
//        o_gnt   - some requester is granted
//        o_gnt_id - granted requester id
module rr_arb2
    import parity_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_gnt_id
);
    always_comb begin
        o_gnt    = |i_valid;
        // On contention the requester not served last wins; a lone valid always wins.
        o_gnt_id = (&i_valid) ? ~i_last : (i_valid[1] ? REQ1 : REQ0);
    end
endmodule

// File: rtl/parity_sched.sv
// parity_sched: arbitrates two number requesters, classifies even/odd and counts per requester.
// Ports: clk, rst_n          - clock, synchronous active-low reset
//        reqX_valid/num/ready - requester X offer, 4-bit number, accept strobe
//        res_valid/ready      - result handshake
//        res_id/num/even      - result payload
//        cnt_clr              - synchronous clear of all counters
//        even_cntX/odd_cntX   - saturating per-requester counts
module parity_sched
    import parity_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_num,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_num,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [3:0]       res_num,
    output logic             res_even,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] even_cnt0,
    output logic [CNT_W-1:0] odd_cnt0,
    output logic [CNT_W-1:0] even_cnt1,
    output logic [CNT_W-1:0] odd_cnt1
);
    state_t           r_state;
    logic             r_last;
    logic             r_id;
    logic [3:0]       r_num;
    logic             r_even;
    logic             r_res_valid;
    logic [CNT_W-1:0] r_cnt [4];
    logic             w_gnt;
    logic             w_gnt_id;
    logic             w_acc;
    logic [1:0]       w_idx;

    rr_arb2 u_arb (
        .i_valid  ({req1_valid, req0_valid}),
        .i_last   (r_last),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    // rst_n gates the readys so nothing is acknowledged while reset is held.
    assign w_acc      = rst_n && (r_state == IDLE) && w_gnt;
    assign req0_ready = w_acc && (w_gnt_id == REQ0);
    assign req1_ready = w_acc && (w_gnt_id == REQ1);
    // Counter slot: {id, odd} -> 0 even0, 1 odd0, 2 even1, 3 odd1.
    assign w_idx      = {r_id, r_num[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= REQ1;
            r_id        <= REQ0;
            r_num       <= '0;
            r_even      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt) begin
                    r_id    <= w_gnt_id;
                    r_num   <= w_gnt_id ? req1_num : req0_num;
                    r_last  <= w_gnt_id;
                    r_state <= CLASSIFY;
                end
                CLASSIFY: begin
                    r_even      <= ~r_num[0];
                    r_res_valid <= 1'b1;
                    r_state     <= OUTPUT;
                end
                OUTPUT: if (res_ready) begin
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else if (r_state == CLASSIFY && r_cnt[w_idx] != '1) begin
            r_cnt[w_idx] <= r_cnt[w_idx] + 1'b1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_id;
    assign res_num   = r_num;
    assign res_even  = r_even;
    assign even_cnt0 = r_cnt[0];
    assign odd_cnt0  = r_cnt[1];
    assign even_cnt1 = r_cnt[2];
    assign odd_cnt1  = r_cnt[3];
endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: randomized and directed checks of parity_sched against a transaction-level model.
module tb_parity_sched;
    import parity_pkg::*;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]       req0_num = '0, req1_num = '0;
    logic             req0_ready, req1_ready;
    logic             res_valid, res_id, res_even;
    logic             res_ready = 1'b1;
    logic [3:0]       res_num;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] even_cnt0, odd_cnt0, even_cnt1, odd_cnt1;

    int checks = 0;
    int errors = 0;

    bit m_busy = 0;
    int m_age = 0;
    bit m_last = 1;
    bit m_id = 0;
    int m_num = 0;
    bit m_clean = 1;
    int m_even [2] = '{0, 0};
    int m_odd  [2] = '{0, 0};

    parity_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_num(req0_num), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_num(req1_num), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_num(res_num), .res_even(res_even),
        .cnt_clr(cnt_clr),
        .even_cnt0(even_cnt0), .odd_cnt0(odd_cnt0),
        .even_cnt1(even_cnt1), .odd_cnt1(odd_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the coming edge.
    task automatic step();
        bit g, gid, out;
        g   = rst_n && !m_busy && (req0_valid || req1_valid);
        gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
        out = m_busy && m_age >= 1;
        check("req0_ready", req0_ready, g && !gid);
        check("req1_ready", req1_ready, g && gid);
        check("res_valid", res_valid, out);
        if (out) begin
            check("res_id", res_id, m_id);
            check("res_num", res_num, m_num);
            check("res_even", res_even, (m_num % 2) == 0);
        end
        if (m_clean) check("res_payload_reset", {res_id, res_num, res_even}, 0);
        check("counters", {even_cnt0, odd_cnt0, even_cnt1, odd_cnt1},
              {m_even[0][CNT_W-1:0], m_odd[0][CNT_W-1:0], m_even[1][CNT_W-1:0], m_odd[1][CNT_W-1:0]});
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_clean = 1;
            m_even = '{0, 0}; m_odd = '{0, 0};
        end else begin
            if (m_busy && m_age == 0) begin
                if (m_num % 2 == 0) m_even[m_id] = (m_even[m_id] < MAXC) ? m_even[m_id] + 1 : MAXC;
                else m_odd[m_id] = (m_odd[m_id] < MAXC) ? m_odd[m_id] + 1 : MAXC;
            end
            if (cnt_clr) begin m_even = '{0, 0}; m_odd = '{0, 0}; end
            if (g) begin
                m_busy = 1; m_age = 0; m_id = gid; m_last = gid; m_clean = 0;
                m_num = gid ? int'(req1_num) : int'(req0_num);
            end else if (m_busy) begin
                if (m_age >= 1 && res_ready) m_busy = 0;
                else m_age++;
            end
        end
    endtask

    task automatic cyc(input bit v0, input int n0, input bit v1, input int n1,
                       input bit rr, input bit clr, input bit rn);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_num = 4'(n0);
        req1_valid = v1; req1_num = 4'(n1);
        res_ready = rr; cnt_clr = clr; rst_n = rn;
        @(negedge clk);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0, 1);
    endtask

    initial begin
        // reset held with requests pending: readys must stay low
        for (int i = 0; i < 3; i++) cyc(1, 3, 1, 4, 1, 0, 0);
        idle(2);
        // single request: req0 number 2
        cyc(1, 2, 0, 0, 1, 0, 1);
        idle(4);
        check("single_even_cnt0", even_cnt0, 1);
        // contention: both valid continuously
        for (int i = 0; i < 12; i++) cyc(1, 7, 1, 6, 1, 0, 1);
        idle(4);
        // backpressure: five cycles of res_ready low in OUTPUT
        cyc(0, 0, 1, 9, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 5, 1, 8, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        idle(4);
        // saturation: five odd numbers from req1
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 2 * i + 1, 1, 0, 1);
            idle(3);
        end
        check("sat_odd_cnt1", odd_cnt1, MAXC);
        // cnt_clr in CLASSIFY: result still delivered
        cyc(1, 4, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 1);
        idle(4);
        check("clr_even_cnt0", even_cnt0, 0);
        // reset during CLASSIFY, then contention must favour req0
        cyc(0, 0, 1, 6, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(1, 1, 1, 2, 1, 0, 1);
        check("rst_grant_req0", req0_ready, 1);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 2500; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom_range(0, 99) != 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
